// File: rtl/mic_pkg.sv
// Shared types and constants for the Pmod MIC3 (ADCS7476) capture path.
package mic_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CS_SETUP,
        SHIFT,
        DONE
    } mic_state_e;

    localparam int FRAME_BITS = 16;
    localparam int DATA_BITS  = 12;
    localparam int LEAD_ZEROS = 4;
    localparam int WAVE_BITS  = 10;

    // Number of system clock cycles between conversions.
    function automatic int period(input int clk_hz, input int sample_hz);
        return clk_hz / sample_hz;
    endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running 0..PERIOD-1 counter with a one-cycle strobe on the terminal count.
module sample_tick_gen #(
    parameter int PERIOD = 5000
) (
    input  logic CLOCK,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    logic [CW-1:0] count_q;

    // NOTE: sequential state is always updated with <= so every register samples pre-edge values.
    always_ff @(posedge CLOCK or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (count_q == LAST) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + 1'b1;
        end
    end

    assign tick = (count_q == LAST);

endmodule

// File: rtl/mic_adc_capture.sv
// SPI master for the ADCS7476: one 16-bit frame per sample tick, 12-bit result
// with valid strobe, 10-bit display sample, and a strobe for corrupt frames.
module mic_adc_capture
    import mic_pkg::*;
#(
    parameter int CLK_HZ    = 100_000_000,
    parameter int SAMPLE_HZ = 20_000,
    parameter int SCLK_DIV  = 25
) (
    input  logic                 CLOCK,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 mic_miso,
    output logic                 mic_sclk,
    output logic                 mic_cs_n,
    output logic [DATA_BITS-1:0] sample,
    output logic                 sample_valid,
    output logic [WAVE_BITS-1:0] wave_sample,
    output logic                 frame_err
);

    localparam int PERIOD = period(CLK_HZ, SAMPLE_HZ);
    localparam int HW     = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int EW     = 5;

    // A whole frame must finish before the next tick, so ticks are never seen outside IDLE.
    generate
        if (2 + 33 * SCLK_DIV >= PERIOD) begin : g_period_check
            $error("mic_adc_capture: frame length 2+33*SCLK_DIV must be below PERIOD");
        end
    endgenerate

    logic tick;

    sample_tick_gen #(
        .PERIOD (PERIOD)
    ) u_tick (
        .CLOCK (CLOCK),
        .rst_n (rst_n),
        .tick  (tick)
    );

    mic_state_e           state_q, state_d;
    logic [HW-1:0]        hcnt_q, hcnt_d;
    logic [EW-1:0]        ecnt_q, ecnt_d;
    logic [FRAME_BITS-1:0] shift_q;
    logic                 sclk_q, sclk_d;
    logic                 cs_n_q, cs_n_d;
    logic                 valid_q, valid_d;
    logic                 err_q, err_d;
    logic [DATA_BITS-1:0] sample_q;
    logic [WAVE_BITS-1:0] wave_q;
    logic                 shift_en;
    logic                 load;
    logic                 half_done;

    assign half_done = (hcnt_q == HW'(SCLK_DIV - 1));

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_d  = state_q;
        hcnt_d   = hcnt_q;
        ecnt_d   = ecnt_q;
        sclk_d   = 1'b1;
        shift_en = 1'b0;
        load     = 1'b0;
        valid_d  = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (tick && enable) begin
                    state_d = CS_SETUP;
                    hcnt_d  = '0;
                end
            end
            CS_SETUP: begin
                if (half_done) begin
                    state_d = SHIFT;
                    hcnt_d  = '0;
                    ecnt_d  = '0;
                    sclk_d  = 1'b0;
                end else begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end
            SHIFT: begin
                sclk_d = sclk_q;
                if (half_done) begin
                    hcnt_d = '0;
                    if (!sclk_q) begin
                        // The rising SCLK edge is where the ADC's bit is captured.
                        sclk_d   = 1'b1;
                        shift_en = 1'b1;
                        ecnt_d   = ecnt_q + 1'b1;
                    end else if (ecnt_q == EW'(FRAME_BITS)) begin
                        state_d = DONE;
                    end else begin
                        sclk_d = 1'b0;
                    end
                end else begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                if (shift_q[FRAME_BITS-1 -: LEAD_ZEROS] == '0) begin
                    load    = 1'b1;
                    valid_d = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        cs_n_d = !((state_d == CS_SETUP) || (state_d == SHIFT));
    end

    always_ff @(posedge CLOCK or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            hcnt_q   <= '0;
            ecnt_q   <= '0;
            shift_q  <= '0;
            sclk_q   <= 1'b1;
            cs_n_q   <= 1'b1;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            sample_q <= '0;
            wave_q   <= '0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            ecnt_q  <= ecnt_d;
            sclk_q  <= sclk_d;
            cs_n_q  <= cs_n_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            if (shift_en) begin
                shift_q <= {shift_q[FRAME_BITS-2:0], mic_miso};
            end
            if (load) begin
                sample_q <= shift_q[DATA_BITS-1:0];
                wave_q   <= shift_q[DATA_BITS-1 -: WAVE_BITS];
            end
        end
    end

    assign mic_sclk     = sclk_q;
    assign mic_cs_n     = cs_n_q;
    assign sample       = sample_q;
    assign sample_valid = valid_q;
    assign wave_sample  = wave_q;
    assign frame_err    = err_q;

endmodule

// File: tb/tb_mic_adc_capture.sv
// Self-checking bench for mic_adc_capture with an ADCS7476 serial-data model.
module tb_mic_adc_capture;

    localparam int PERIOD  = 5000;
    localparam int LATENCY = 827;
    localparam int NVEC    = 6;

    logic        CLOCK    = 1'b0;
    logic        rst_n    = 1'b0;
    logic        enable   = 1'b0;
    logic        mic_miso = 1'b0;
    logic        mic_sclk;
    logic        mic_cs_n;
    logic [11:0] sample;
    logic        sample_valid;
    logic [9:0]  wave_sample;
    logic        frame_err;

    always #5 CLOCK = ~CLOCK;

    mic_adc_capture dut (
        .CLOCK        (CLOCK),
        .rst_n        (rst_n),
        .enable       (enable),
        .mic_miso     (mic_miso),
        .mic_sclk     (mic_sclk),
        .mic_cs_n     (mic_cs_n),
        .sample       (sample),
        .sample_valid (sample_valid),
        .wave_sample  (wave_sample),
        .frame_err    (frame_err)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Cycles since reset release, advanced on every rising clock edge.
    int cyc = 0;
    always @(posedge CLOCK or negedge rst_n) begin
        if (!rst_n) cyc = 0;
        else        cyc = cyc + 1;
    end

    // ADC model: each SCLK falling edge inside a frame presents the next bit, MSB first.
    logic [15:0] bfm_frame = 16'h0000;
    int          bfm_idx   = 0;
    always @(negedge mic_cs_n) bfm_idx = 0;
    always @(negedge mic_sclk) begin
        if (!mic_cs_n && bfm_idx < 16) begin
            mic_miso = bfm_frame[15 - bfm_idx];
            bfm_idx++;
        end
    end

    // Bus monitor, sampled on the falling clock edge.
    int   fall_cnt = 0, fall_cyc = 0, rise_cnt = 0;
    int   valid_cnt = 0, err_cnt = 0, strobe_cyc = 0, viol = 0;
    logic cs_prev = 1'b1, sclk_prev = 1'b1, valid_prev = 1'b0, err_prev = 1'b0;
    always @(negedge CLOCK) begin
        if (cs_prev && !mic_cs_n) begin
            fall_cnt++;
            fall_cyc = cyc;
            rise_cnt = 0;
        end
        if (!mic_cs_n && !sclk_prev && mic_sclk) rise_cnt++;
        if (sample_valid) begin valid_cnt++; strobe_cyc = cyc; end
        if (frame_err)    begin err_cnt++;   strobe_cyc = cyc; end
        if ((sample_valid && frame_err) || (sample_valid && valid_prev) || (frame_err && err_prev))
            viol++;
        cs_prev    = mic_cs_n;
        sclk_prev  = mic_sclk;
        valid_prev = sample_valid;
        err_prev   = frame_err;
    end

    task automatic step();
        @(negedge CLOCK);
        #1;
    endtask

    task automatic wait_fall(input int budget, output bit ok);
        int start;
        start = fall_cnt;
        for (int i = 0; i < budget && fall_cnt == start; i++) step();
        ok = (fall_cnt != start);
    endtask

    task automatic wait_strobe(input int budget, output bit ok);
        int start;
        start = valid_cnt + err_cnt;
        for (int i = 0; i < budget && (valid_cnt + err_cnt) == start; i++) step();
        ok = ((valid_cnt + err_cnt) != start);
    endtask

    typedef struct {
        logic [15:0] frame;
        bit          exp_valid;
        logic [11:0] exp_sample;
        logic [9:0]  exp_wave;
    } vec_t;

    vec_t vecs[NVEC];

    // Reference behaviour: a frame with four leading zeros replaces the held value.
    logic [11:0] held = 12'h000;
    task automatic model_frame(input logic [15:0] f, output vec_t v);
        bit good;
        good = (f >> 12) == 0;
        if (good) held = 12'(f % 4096);
        v.frame      = f;
        v.exp_valid  = good;
        v.exp_sample = held;
        v.exp_wave   = 10'(held / 4);
    endtask

    initial begin
        bit          ok;
        int          prev_fall;
        int          f5;
        int          falls_before;
        int          strobes_before;
        logic [15:0] rnd;
        vec_t        v;

        vecs[0] = '{16'h0ABC, 1'b1, 12'hABC, 10'h2AF};
        vecs[1] = '{16'h8123, 1'b0, 12'hABC, 10'h2AF};
        vecs[2] = '{16'h0FFF, 1'b1, 12'hFFF, 10'h3FF};
        vecs[3] = '{16'h0000, 1'b1, 12'h000, 10'h000};
        held = 12'h000;
        rnd = {4'h0, 12'($urandom)};
        model_frame(rnd, vecs[4]);
        rnd = {4'($urandom_range(1, 15)), 12'($urandom)};
        model_frame(rnd, vecs[5]);

        // Reset state.
        repeat (3) step();
        check("rst_cs_n", mic_cs_n, 1);
        check("rst_sclk", mic_sclk, 1);
        check("rst_sample", sample, 0);
        check("rst_wave", wave_sample, 0);
        check("rst_valid", sample_valid, 0);
        check("rst_err", frame_err, 0);

        @(negedge CLOCK);
        rst_n = 1'b1;
        while (cyc < PERIOD - 1) step();
        check("pre_tick_no_frame", fall_cnt, 0);
        check("pre_tick_no_strobe", valid_cnt + err_cnt, 0);
        check("pre_tick_cs_n", mic_cs_n, 1);

        // Table of back-to-back frames.
        enable    = 1'b1;
        prev_fall = 0;
        for (int i = 0; i < NVEC; i++) begin
            bfm_frame = vecs[i].frame;
            wait_fall(PERIOD + 10, ok);
            check($sformatf("v%0d_fall_seen", i), ok, 1);
            if (i == 0) check("v0_fall_cyc", fall_cyc, PERIOD);
            else        check($sformatf("v%0d_fall_spacing", i), fall_cyc - prev_fall, PERIOD);
            prev_fall = fall_cyc;
            wait_strobe(LATENCY + 10, ok);
            check($sformatf("v%0d_strobe_seen", i), ok, 1);
            check($sformatf("v%0d_latency", i), strobe_cyc - (fall_cyc - 1), LATENCY);
            check($sformatf("v%0d_sclk_rises", i), rise_cnt, 16);
            check($sformatf("v%0d_valid", i), sample_valid, vecs[i].exp_valid);
            check($sformatf("v%0d_err", i), frame_err, !vecs[i].exp_valid);
            check($sformatf("v%0d_sample", i), sample, vecs[i].exp_sample);
            check($sformatf("v%0d_wave", i), wave_sample, vecs[i].exp_wave);
        end

        // Enable dropped during SHIFT: frame completes, later ticks ignored.
        model_frame({4'h0, 12'($urandom)}, v);
        bfm_frame = v.frame;
        wait_fall(PERIOD + 10, ok);
        check("en_fall_seen", ok, 1);
        f5 = fall_cyc;
        repeat (100) step();
        enable = 1'b0;
        wait_strobe(LATENCY + 10, ok);
        check("en_strobe_seen", ok, 1);
        check("en_valid", sample_valid, 1);
        check("en_sample", sample, v.exp_sample);
        check("en_wave", wave_sample, v.exp_wave);
        falls_before = fall_cnt;
        while (cyc < f5 + 3 * PERIOD) step();
        check("en_idle_3_ticks", fall_cnt, falls_before);
        check("en_idle_cs_n", mic_cs_n, 1);
        enable    = 1'b1;
        bfm_frame = 16'h0FFF;
        wait_fall(PERIOD + 10, ok);
        check("en_restart_seen", ok, 1);
        check("en_restart_cyc", fall_cyc, f5 + 4 * PERIOD);

        // Reset at the 10th SCLK rising edge of the restarted frame.
        for (int i = 0; i < 2000 && rise_cnt < 10; i++) step();
        check("mid_edge10", rise_cnt, 10);
        strobes_before = valid_cnt + err_cnt;
        rst_n = 1'b0;
        #1;
        check("mid_rst_cs_n", mic_cs_n, 1);
        check("mid_rst_sclk", mic_sclk, 1);
        check("mid_rst_sample", sample, 0);
        repeat (2) step();
        @(negedge CLOCK);
        rst_n = 1'b1;
        held  = 12'h000;
        model_frame(16'h0555, v);
        bfm_frame = v.frame;
        wait_fall(PERIOD + 10, ok);
        check("post_rst_fall_seen", ok, 1);
        check("post_rst_fall_cyc", fall_cyc, PERIOD);
        wait_strobe(LATENCY + 10, ok);
        check("post_rst_strobe_seen", ok, 1);
        check("post_rst_one_strobe", valid_cnt + err_cnt, strobes_before + 1);
        check("post_rst_valid", sample_valid, 1);
        check("post_rst_sample", sample, v.exp_sample);
        check("post_rst_wave", wave_sample, v.exp_wave);

        repeat (3) step();
        check("strobe_width_exclusive", viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
